// File: rtl/xadc_pkg.sv
// Shared types and constants for the XADC DRP scan scheduler.
package xadc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG_ISSUE,
    ST_CFG_WAIT,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_RD_NEXT
  } state_e;

  localparam logic [6:0] ADDR_VAUX0 = 7'h10;
  localparam logic [6:0] ADDR_CFG0  = 7'h40;
  localparam logic [6:0] ADDR_CFG1  = 7'h41;

  // Result registers are left-justified: the 12-bit conversion sits in [15:4].
  localparam int SMP_MSB = 15;
  localparam int SMP_LSB = 4;
  localparam int SMP_W   = SMP_MSB - SMP_LSB + 1;

  function automatic int chan_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xadc_drp_sched_if.sv
// DRP bus between the scan scheduler (master) and the XADC primitive (slave).
interface xadc_drp_sched_if;
  logic [6:0]  drpAddrOut;
  logic        drpEnOut;
  logic        drpWeOut;
  logic [15:0] drpDiOut;
  logic [15:0] drpDoIn;
  logic        drpRdyIn;

  modport master (output drpAddrOut, drpEnOut, drpWeOut, drpDiOut,
                  input  drpDoIn, drpRdyIn);
  modport slave  (input  drpAddrOut, drpEnOut, drpWeOut, drpDiOut,
                  output drpDoIn, drpRdyIn);
endinterface

// File: rtl/xadc_chan_sel.sv
// Finds the lowest set mask bit strictly above idx (or the lowest set bit
// at all when from_start is high).
module xadc_chan_sel import xadc_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = chan_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   idx,
  input  logic              from_start,
  output logic              found,
  output logic [CH_W-1:0]   nxt
);

  // Scanning downward lets the last hit be the lowest qualifying bit.
  always_comb begin
    found = 1'b0;
    nxt   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (from_start || i > int'(idx))) begin
        found = 1'b1;
        nxt   = CH_W'(i);
      end
    end
  end

endmodule

// File: rtl/xadc_drp_sched.sv
// XADC DRP sequencer: scans enabled aux channels on each EOC and arbitrates
// a single config-write requester against those scans.
module xadc_drp_sched import xadc_pkg::*; #(
  parameter int         NUM_CH      = 4,
  parameter logic [6:0] BASE_ADDR   = ADDR_VAUX0,
  parameter int         TIMEOUT_CYC = 64
) (
  input  logic                      clkIn,
  input  logic                      rstIn,
  input  logic                      enIn,
  input  logic [NUM_CH-1:0]         chanMaskIn,
  input  logic                      eocIn,
  input  logic                      cfgReqIn,
  input  logic [6:0]                cfgAddrIn,
  input  logic [15:0]               cfgDataIn,
  output logic                      cfgAckOut,
  xadc_drp_sched_if.master          drp,
  output logic                      sampleValidOut,
  output logic [chan_w(NUM_CH)-1:0] sampleChanOut,
  output logic [SMP_W-1:0]          sampleDataOut,
  output logic                      timeoutOut,
  output logic                      busyOut
);

  localparam int CH_W  = chan_w(NUM_CH);
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e              state_q, state_d;
  logic                pend_q, pend_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [6:0]          addr_q, addr_d;
  logic                en_q, en_d, we_q, we_d;
  logic [15:0]         di_q, di_d;
  logic                ack_q, ack_d, vld_q, vld_d, tmo_q, tmo_d, busy_q, busy_d;
  logic [CH_W-1:0]     schan_q, schan_d;
  logic [SMP_W-1:0]    sdata_q, sdata_d;
  logic                sel_found, expired;
  logic [CH_W-1:0]     sel_nxt;

  // In IDLE the selector looks at the live mask; mid-scan it walks the latched one.
  xadc_chan_sel #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_sel (
    .mask       ((state_q == ST_IDLE) ? chanMaskIn : mask_q),
    .idx        (ch_q),
    .from_start (state_q == ST_IDLE),
    .found      (sel_found),
    .nxt        (sel_nxt)
  );

  always_comb begin
    state_d = state_q;  pend_d  = pend_q;  mask_d  = mask_q;
    ch_d    = ch_q;     cnt_d   = cnt_q;
    addr_d  = '0;       en_d    = 1'b0;    we_d    = 1'b0;    di_d = '0;
    ack_d   = 1'b0;     vld_d   = 1'b0;    tmo_d   = 1'b0;
    schan_d = schan_q;  sdata_d = sdata_q;
    expired = (cnt_q == CNT_LAST);
    if (eocIn) pend_d = 1'b1;
    if (!enIn) pend_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // ack_q masks the request still held during the ack cycle.
        if (cfgReqIn && !ack_q) begin
          state_d = ST_CFG_ISSUE;
          en_d = 1'b1;  we_d = 1'b1;  addr_d = cfgAddrIn;  di_d = cfgDataIn;
        end else if (enIn && (eocIn || pend_q)) begin
          pend_d = 1'b0;
          if (sel_found) begin
            mask_d = chanMaskIn;  ch_d = sel_nxt;  state_d = ST_RD_ISSUE;
            en_d = 1'b1;  addr_d = BASE_ADDR + 7'(sel_nxt);
          end
        end
      end
      ST_CFG_ISSUE: begin
        state_d = ST_CFG_WAIT;
        cnt_d   = '0;
      end
      ST_CFG_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (drp.drpRdyIn) begin
          ack_d = 1'b1;  state_d = ST_IDLE;
        end else if (expired) begin
          tmo_d = 1'b1;  state_d = ST_IDLE;
        end
      end
      ST_RD_ISSUE: begin
        state_d = ST_RD_WAIT;
        cnt_d   = '0;
      end
      ST_RD_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (drp.drpRdyIn) begin
          vld_d = 1'b1;  schan_d = ch_q;  state_d = ST_RD_NEXT;
          sdata_d = SMP_W'(drp.drpDoIn >> SMP_LSB);
        end else if (expired) begin
          tmo_d = 1'b1;  state_d = ST_RD_NEXT;
        end
      end
      ST_RD_NEXT: begin
        if (sel_found) begin
          ch_d = sel_nxt;  state_d = ST_RD_ISSUE;
          en_d = 1'b1;  addr_d = BASE_ADDR + 7'(sel_nxt);
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      state_q <= ST_IDLE;  pend_q <= 1'b0;  mask_q <= '0;  ch_q <= '0;  cnt_q <= '0;
      addr_q  <= '0;  en_q <= 1'b0;  we_q <= 1'b0;  di_q <= '0;
      ack_q   <= 1'b0;  vld_q <= 1'b0;  tmo_q <= 1'b0;  busy_q <= 1'b0;
      schan_q <= '0;  sdata_q <= '0;
    end else begin
      state_q <= state_d;  pend_q <= pend_d;  mask_q <= mask_d;  ch_q <= ch_d;  cnt_q <= cnt_d;
      addr_q  <= addr_d;  en_q <= en_d;  we_q <= we_d;  di_q <= di_d;
      ack_q   <= ack_d;  vld_q <= vld_d;  tmo_q <= tmo_d;  busy_q <= busy_d;
      schan_q <= schan_d;  sdata_q <= sdata_d;
    end
  end

  assign drp.drpAddrOut = addr_q;
  assign drp.drpEnOut   = en_q;
  assign drp.drpWeOut   = we_q;
  assign drp.drpDiOut   = di_q;
  assign cfgAckOut      = ack_q;
  assign sampleValidOut = vld_q;
  assign sampleChanOut  = schan_q;
  assign sampleDataOut  = sdata_q;
  assign timeoutOut     = tmo_q;
  assign busyOut        = busy_q;

endmodule

// File: tb/tb_xadc_drp_sched.sv
// Directed bench for xadc_drp_sched: scans, config arbitration, timeouts,
// EOC coalescing, mid-transaction reset and idle-suppression cases.
module tb_xadc_drp_sched;
  import xadc_pkg::*;

  localparam int NUM_CH = 4;
  localparam int TMO    = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  mask = '0;
  logic        eoc = 1'b0;
  logic        cfg_req = 1'b0;
  logic [6:0]  cfg_addr = '0;
  logic [15:0] cfg_data = '0;
  logic        cfg_ack, smp_vld, tmo, busy;
  logic [1:0]  smp_chan;
  logic [11:0] smp_data;
  int          checks = 0;
  int          errors = 0;

  xadc_drp_sched_if drp ();

  xadc_drp_sched #(.NUM_CH(NUM_CH), .BASE_ADDR(ADDR_VAUX0), .TIMEOUT_CYC(TMO)) dut (
    .clkIn          (clk),
    .rstIn          (rst_n),
    .enIn           (en),
    .chanMaskIn     (mask),
    .eocIn          (eoc),
    .cfgReqIn       (cfg_req),
    .cfgAddrIn      (cfg_addr),
    .cfgDataIn      (cfg_data),
    .cfgAckOut      (cfg_ack),
    .drp            (drp),
    .sampleValidOut (smp_vld),
    .sampleChanOut  (smp_chan),
    .sampleDataOut  (smp_data),
    .timeoutOut     (tmo),
    .busyOut        (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_en(input string tag);
    int n = 0;
    while (drp.drpEnOut !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_en_seen"}, 32'(drp.drpEnOut), 1);
  endtask

  task automatic scan_read(input string tag, input logic [6:0] addr, input logic [1:0] ch,
                           input logic [15:0] dat, input logic [11:0] exp_data);
    wait_en(tag);
    chk({tag, "_addr"}, 32'(drp.drpAddrOut), 32'(addr));
    chk({tag, "_we"}, 32'(drp.drpWeOut), 0);
    step();
    chk({tag, "_en_gap"}, 32'(drp.drpEnOut), 0);
    drp.drpRdyIn = 1'b1;
    drp.drpDoIn  = dat;
    step();
    drp.drpRdyIn = 1'b0;
    chk({tag, "_valid"}, 32'(smp_vld), 1);
    chk({tag, "_chan"}, 32'(smp_chan), 32'(ch));
    chk({tag, "_data"}, 32'(smp_data), 32'(exp_data));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int act;
    drp.drpRdyIn = 1'b0;
    drp.drpDoIn  = '0;

    #2;
    chk("rst_en", 32'(drp.drpEnOut), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(smp_vld), 0);
    chk("rst_ack", 32'(cfg_ack), 0);
    chk("rst_tmo", 32'(tmo), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    en    = 1'b1;
    step();

    // Scan of mask 1011: channels 0, 1, 3
    mask = 4'b1011;
    eoc  = 1'b1;
    step();
    eoc  = 1'b0;
    chk("t1_latency_en", 32'(drp.drpEnOut), 1);
    chk("t1_busy", 32'(busy), 1);
    scan_read("t1_c0", 7'h10, 2'd0, 16'hABC5, 12'hABC);
    scan_read("t1_c1", 7'h11, 2'd1, 16'h1234, 12'h123);
    scan_read("t1_c3", 7'h13, 2'd3, 16'hFFF0, 12'hFFF);
    chk("t1_busy_last", 32'(busy), 1);
    step();
    chk("t1_busy_fall", 32'(busy), 0);
    chk("t1_valid_end", 32'(smp_vld), 0);

    // Config request and EOC in the same idle cycle
    cfg_req  = 1'b1;
    cfg_addr = ADDR_CFG1;
    cfg_data = 16'h2000;
    eoc      = 1'b1;
    step();
    eoc = 1'b0;
    chk("t2_cfg_en", 32'(drp.drpEnOut), 1);
    chk("t2_cfg_we", 32'(drp.drpWeOut), 1);
    chk("t2_cfg_addr", 32'(drp.drpAddrOut), 32'h41);
    chk("t2_cfg_di", 32'(drp.drpDiOut), 32'h2000);
    step();
    drp.drpRdyIn = 1'b1;
    step();
    drp.drpRdyIn = 1'b0;
    chk("t2_ack", 32'(cfg_ack), 1);
    chk("t2_ack_en", 32'(drp.drpEnOut), 0);
    cfg_req = 1'b0;
    step();
    chk("t2_ack_pulse", 32'(cfg_ack), 0);
    chk("t2_pend_start", 32'(drp.drpEnOut), 1);
    scan_read("t2_c0", 7'h10, 2'd0, 16'h0010, 12'h001);
    scan_read("t2_c1", 7'h11, 2'd1, 16'h4567, 12'h456);
    scan_read("t2_c3", 7'h13, 2'd3, 16'h89AB, 12'h89A);
    step();
    chk("t2_idle", 32'(busy), 0);

    // Config write that never gets a ready
    cfg_req  = 1'b1;
    cfg_addr = ADDR_CFG0;
    cfg_data = 16'h0005;
    step();
    cfg_req = 1'b0;
    chk("tc_addr", 32'(drp.drpAddrOut), 32'h40);
    repeat (TMO) step();
    chk("tc_tmo_early", 32'(tmo), 0);
    step();
    chk("tc_tmo", 32'(tmo), 1);
    chk("tc_no_ack", 32'(cfg_ack), 0);
    chk("tc_idle", 32'(busy), 0);

    // Read timeout on channel 1 of mask 0011
    mask = 4'b0011;
    eoc  = 1'b1;
    step();
    eoc  = 1'b0;
    scan_read("t3_c0", 7'h10, 2'd0, 16'h5550, 12'h555);
    wait_en("t3_c1");
    chk("t3_c1_addr", 32'(drp.drpAddrOut), 32'h11);
    act = 0;
    repeat (TMO) begin
      step();
      if (smp_vld === 1'b1) act++;
    end
    chk("t3_tmo_early", 32'(tmo), 0);
    step();
    chk("t3_tmo", 32'(tmo), 1);
    chk("t3_no_sample", 32'(act + int'(smp_vld)), 0);
    chk("t3_busy_next", 32'(busy), 1);
    step();
    chk("t3_idle", 32'(busy), 0);
    chk("t3_tmo_pulse", 32'(tmo), 0);

    // Three EOCs during one scan coalesce into one extra scan
    mask = 4'b0001;
    eoc  = 1'b1;
    step();
    eoc  = 1'b0;
    chk("t4_en", 32'(drp.drpEnOut), 1);
    for (int k = 0; k < 3; k++) begin
      step();
      eoc = 1'b1;
      step();
      eoc = 1'b0;
    end
    drp.drpRdyIn = 1'b1;
    drp.drpDoIn  = 16'h7771;
    step();
    drp.drpRdyIn = 1'b0;
    chk("t4_valid", 32'(smp_vld), 1);
    chk("t4_data", 32'(smp_data), 32'h777);
    scan_read("t4_extra", 7'h10, 2'd0, 16'h8880, 12'h888);
    act = 0;
    repeat (20) begin
      step();
      if (drp.drpEnOut === 1'b1) act++;
    end
    chk("t4_no_third_scan", 32'(act), 0);
    chk("t4_idle", 32'(busy), 0);

    // Reset asserted while waiting for ready
    eoc = 1'b1;
    step();
    eoc = 1'b0;
    wait_en("t5");
    step();
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_en", 32'(drp.drpEnOut), 0);
    chk("t5_addr", 32'(drp.drpAddrOut), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_data", 32'(smp_data), 0);
    chk("t5_chan", 32'(smp_chan), 0);
    chk("t5_valid", 32'(smp_vld), 0);
    chk("t5_tmo", 32'(tmo), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drp.drpRdyIn = 1'b1;
    drp.drpDoIn  = 16'hFFFF;
    step();
    drp.drpRdyIn = 1'b0;
    step();
    chk("t5_late_rdy_valid", 32'(smp_vld), 0);
    chk("t5_late_rdy_busy", 32'(busy), 0);
    chk("t5_late_rdy_data", 32'(smp_data), 0);

    // Zero mask, then scans disabled
    mask = 4'b0000;
    eoc  = 1'b1;
    step();
    eoc  = 1'b0;
    act = 0;
    repeat (6) begin
      if (drp.drpEnOut === 1'b1 || busy === 1'b1) act++;
      step();
    end
    chk("t6_zero_mask", 32'(act), 0);
    en   = 1'b0;
    mask = 4'b1111;
    eoc  = 1'b1;
    step();
    eoc  = 1'b0;
    act = 0;
    repeat (4) begin
      if (drp.drpEnOut === 1'b1 || busy === 1'b1) act++;
      step();
    end
    en = 1'b1;
    repeat (10) begin
      if (drp.drpEnOut === 1'b1 || busy === 1'b1) act++;
      step();
    end
    chk("t6_disabled", 32'(act), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
